prefix_adder_pipe: RTL and testbench
====================================

# prefix_adder_pipe

Parametrised, pipelined sparse-2 (Han-Carlson style) parallel-prefix adder/subtractor with valid/ready flow control. It generalises the team's fixed 16-bit prefix adder in four ways: configurable width, configurable pipeline depth, an add/subtract mode, and carry-in, carry-out and signed-overflow outputs. It sits in the FIR datapath between the multiplier outputs and the accumulator/cascade adders, so that wide sums close timing at the filter clock.

## Interface
- WIDTH, 16, operand/sum width; power of two, 8..64.
- STAGE_LEVELS, 2, prefix levels between pipeline register ranks; 1..L, where L = log2(WIDTH)+1.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts the beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; ignored when sub=1.
- sub  in  1  0: a+b+cin; 1: a-b, computed as a+~b+1.
- out_valid  out  1  result beat present.
- out_ready  in  1  downstream accepts the result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  carry out of the MSB; for sub, 1 means no borrow.
- ovf  out  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

## Operation
- Pre-computation on the registered operands:
  - b' = sub ? ~b : b; c0 = sub ? 1 : cin.
  - p = a ^ b', g = a & b'.
  - c0 is treated as the generate term of bit position −1.
- Prefix tree, L = log2(WIDTH)+1 levels:
  - Level 1: black/grey cells combine each odd bit with the even bit below it.
  - Levels 2..L−1: Kogge-Stone over the odd positions only, spans 2, 4, …, WIDTH/2.
  - Level L: one grey-cell rank resolves the even positions from the odd position below them.
  - Grey cells are used wherever the span reaches bit −1; black cells everywhere else.
- Post-computation: sum[i] = p[i] ^ c[i]; cout = c[WIDTH]; ovf = c[WIDTH] ^ c[WIDTH−1].
- Pipeline ranks:
  - Input register: a, b, cin, sub and valid.
  - One register rank after every STAGE_LEVELS prefix levels, excluding level L.
  - Output register: sum, cout, ovf, valid.
  - Each rank carries the p vector and the in-flight G/P values it needs, plus one valid bit.
- Flow control uses a single global enable: en = out_ready | ~out_valid.
  - All ranks, including their valid bits, advance only when en=1.
  - in_ready = en. This is a combinational path from out_ready.
  - Accept occurs when in_valid & in_ready; the input valid bit loads in_valid & en.
  - Bubbles are not compressed; they shift through like data.
- No internal state machine beyond the valid shift chain. Results leave in acceptance order, never dropped or duplicated.

## Timing
- Latency LAT = 2 + floor((L−1)/STAGE_LEVELS) cycles, measured from the accept edge to the edge where out_valid rises, with no stall.
  - WIDTH=16, STAGE_LEVELS=2: LAT=4.
  - WIDTH=16, STAGE_LEVELS=5: LAT=2.
  - WIDTH=32, STAGE_LEVELS=2: LAT=4.
- Throughput is one result per cycle while out_ready=1.
- With out_valid=1 and out_ready=0, every rank holds and outputs stay stable. in_ready=0 in that same cycle.
- out_ready=0 while out_valid=0: the pipeline still advances, because en=1.
- Simultaneous accept and emit in one cycle is legal and required at full rate.
- Reset values:
  - out_valid=0, sum=0, cout=0, ovf=0.
  - All internal valid bits are 0.
  - Data registers reset to 0.
  - in_ready=1 in the cycle after reset deasserts.
- Reset asserted mid-stream:
  - All in-flight beats are discarded at that edge.
  - in_ready=0 while rst=1; nothing is accepted during reset.
  - The first post-reset result appears LAT cycles after the first post-reset accept.
- Operand and control inputs only need to be stable at accepting edges.

## Test plan
Bench configuration: WIDTH=16, STAGE_LEVELS=2, LAT=4.
- Reset: hold rst for 3 cycles with random inputs toggling. Required: out_valid=0, sum=0x0000, cout=0, ovf=0 throughout; in_ready=1 on the first cycle after release.
- Add wrap: a=0xFFFF, b=0x0001, cin=0, sub=0, accepted at cycle t. Required: out_valid at t+4, sum=0x0000, cout=1, ovf=0. Repeat with cin=1: sum=0x0001.
- Signed overflow: a=0x7FFF, b=0x0001 (add) → sum=0x8000, cout=0, ovf=1. Then a=0x8000, b=0x0001, sub=1 → sum=0x7FFF, cout=1, ovf=1. Then a=0x0000, b=0x0001, sub=1 → sum=0xFFFF, cout=0, ovf=0.
- Backpressure: stream 200 random beats while out_ready follows a random 50% pattern. Required:
  - every result matches the golden a±b model, in order;
  - no beat lost or duplicated;
  - outputs hold steady while out_valid=1 and out_ready=0.
- Full-rate: in_valid=1 and out_ready=1 for 64 cycles. Required: 64 consecutive out_valid cycles starting 4 cycles after the first accept.
- Reset mid-stream: assert rst for 1 cycle with 3 beats in flight. Required: none of those beats emerges; a beat accepted 2 cycles later appears exactly 4 cycles after its accept.

Source files
------------

// File: rtl/prefix_adder_pipe.sv
// Pipelined sparse-2 (Han-Carlson) parallel-prefix adder/subtractor.
// The input register holds the raw operands. Pre-computation, the prefix tree and
// post-computation run between the input register and the output register. A
// register rank is placed after every STAGE_LEVELS prefix levels, except after
// the final level. All ranks share one enable, en = out_ready | ~out_valid, so a
// stall freezes the whole pipe. Bubbles travel through it like data.
module prefix_adder_pipe #(
    parameter int WIDTH        = 16,
    parameter int STAGE_LEVELS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int L  = $clog2(WIDTH) + 1;        // prefix levels
    localparam int M  = (L - 1) / STAGE_LEVELS;   // intermediate register ranks
    localparam int MR = (M > 0) ? M : 1;          // keep arrays non-empty

    logic en;

    // input register
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             cin_q, cin_d, sub_q, sub_d, vin_q, vin_d;

    // intermediate ranks: group G/P, bitwise p, carry-in and valid
    logic [WIDTH-1:0] rk_g_q [0:MR-1];
    logic [WIDTH-1:0] rk_g_d [0:MR-1];
    logic [WIDTH-1:0] rk_p_q [0:MR-1];
    logic [WIDTH-1:0] rk_p_d [0:MR-1];
    logic [WIDTH-1:0] rk_pr_q[0:MR-1];
    logic [WIDTH-1:0] rk_pr_d[0:MR-1];
    logic             rk_c0_q[0:MR-1];
    logic             rk_c0_d[0:MR-1];
    logic             rk_v_q [0:MR-1];
    logic             rk_v_d [0:MR-1];

    // output register
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d, ovf_q, ovf_d, vout_q, vout_d;

    // pre-computation outputs
    logic [WIDTH-1:0] pre_g, pre_p, pre_pr;
    logic             pre_c0;

    assign en        = out_ready | ~vout_q;
    assign in_ready  = en & ~rst;
    assign out_valid = vout_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

    // Input register: load a new beat (or a bubble) whenever the pipe advances.
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        cin_d = cin_q;
        sub_d = sub_q;
        vin_d = vin_q;
        if (en) begin
            a_d   = a;
            b_d   = b;
            cin_d = cin;
            sub_d = sub;
            vin_d = in_valid;
        end
    end

    // Bitwise p/g. Bit -1 (the carry-in) is merged into bit 0 here, so that
    // bit 0 already spans [-1..0] and the sparse tree needs no extra level for it.
    // Bit 0's group propagate is therefore 0. Every cell whose span reaches bit 0
    // gets a constant-0 P, so its P gate drops out and it reduces to a grey cell.
    always_comb begin
        logic [WIDTH-1:0] bx;
        bx        = sub_q ? ~b_q : b_q;
        pre_c0    = sub_q | cin_q;
        pre_pr    = a_q ^ bx;
        pre_g     = a_q & bx;
        pre_p     = pre_pr;
        pre_g[0]  = pre_g[0] | (pre_pr[0] & pre_c0);
        pre_p[0]  = 1'b0;
    end

    // Prefix tree walked level by level. At each rank boundary the running
    // values are captured into that rank, and later levels continue from the
    // registered copy. The last level feeds the output register.
    always_comb begin
        logic [WIDTH-1:0] g, p, gn, pn, pr;
        logic             c0, v;
        int               s, ri;
        s  = 1;
        ri = 0;
        for (int r = 0; r < MR; r++) begin
            rk_g_d[r]  = rk_g_q[r];
            rk_p_d[r]  = rk_p_q[r];
            rk_pr_d[r] = rk_pr_q[r];
            rk_c0_d[r] = rk_c0_q[r];
            rk_v_d[r]  = rk_v_q[r];
        end
        g  = pre_g;
        p  = pre_p;
        pr = pre_pr;
        c0 = pre_c0;
        v  = vin_q;
        for (int lv = 1; lv <= L; lv++) begin
            // level 1 and level L pair with the neighbour below. The middle
            // levels run Kogge-Stone over the odd bits with doubling span.
            s  = ((lv == 1) || (lv == L)) ? 1 : (1 << (lv - 1));
            gn = g;
            pn = p;
            for (int i = 0; i < WIDTH; i++) begin
                if (((lv < L) && ((i % 2) == 1) && (i >= s)) ||
                    ((lv == L) && ((i % 2) == 0) && (i >= 2))) begin
                    gn[i] = g[i] | (p[i] & g[i - s]);
                    pn[i] = p[i] & p[i - s];
                end
            end
            g = gn;
            p = pn;
            if (((lv % STAGE_LEVELS) == 0) && (lv < L)) begin
                ri = lv / STAGE_LEVELS - 1;
                if (en) begin
                    rk_g_d[ri]  = g;
                    rk_p_d[ri]  = p;
                    rk_pr_d[ri] = pr;
                    rk_c0_d[ri] = c0;
                    rk_v_d[ri]  = v;
                end
                g  = rk_g_q[ri];
                p  = rk_p_q[ri];
                pr = rk_pr_q[ri];
                c0 = rk_c0_q[ri];
                v  = rk_v_q[ri];
            end
        end
        // g[i] is now the carry into bit i+1. The carry into bit 0 is c0.
        sum_d  = sum_q;
        cout_d = cout_q;
        ovf_d  = ovf_q;
        vout_d = vout_q;
        if (en) begin
            sum_d  = pr ^ {g[WIDTH-2:0], c0};
            cout_d = g[WIDTH-1];
            ovf_d  = g[WIDTH-1] ^ g[WIDTH-2];
            vout_d = v;
        end
    end

    // All pipeline state; a synchronous reset clears data and valid bits alike.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            cin_q  <= 1'b0;
            sub_q  <= 1'b0;
            vin_q  <= 1'b0;
            for (int r = 0; r < MR; r++) begin
                rk_g_q[r]  <= '0;
                rk_p_q[r]  <= '0;
                rk_pr_q[r] <= '0;
                rk_c0_q[r] <= 1'b0;
                rk_v_q[r]  <= 1'b0;
            end
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            vout_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            cin_q  <= cin_d;
            sub_q  <= sub_d;
            vin_q  <= vin_d;
            for (int r = 0; r < MR; r++) begin
                rk_g_q[r]  <= rk_g_d[r];
                rk_p_q[r]  <= rk_p_d[r];
                rk_pr_q[r] <= rk_pr_d[r];
                rk_c0_q[r] <= rk_c0_d[r];
                rk_v_q[r]  <= rk_v_d[r];
            end
            sum_q  <= sum_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
            vout_q <= vout_d;
        end
    end
endmodule

// File: tb/tb_prefix_adder_pipe.sv
// Bench for prefix_adder_pipe at WIDTH=16, STAGE_LEVELS=2 (latency 4).
// The reference is plain integer arithmetic. Results are queued in acceptance
// order and compared as they leave the DUT.
module tb_prefix_adder_pipe;
    localparam int W   = 16;
    localparam int LAT = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int tests = 0;
    int fails = 0;
    logic [17:0] expq[$];

    prefix_adder_pipe #(.WIDTH(W), .STAGE_LEVELS(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // {ovf, cout, sum} from integer arithmetic
    function automatic logic [17:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic ci, input logic s);
        logic [W-1:0] yy;
        logic [W:0]   t;
        logic         of;
        yy = s ? ~y : y;
        t  = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, (s ? 1'b1 : ci)};
        of = (x[W-1] == yy[W-1]) && (t[W-1] != x[W-1]);
        return {of, t[W], t[W-1:0]};
    endfunction

    // Drive one beat, then wait for its result. lat counts edges from the accept edge.
    task automatic run_one(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                           input logic s, output logic acc, output logic [17:0] got,
                           output int lat);
        @(posedge clk); #1;
        a = x; b = y; cin = ci; sub = s; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        acc = in_ready;
        lat = -1;
        got = '0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            #1;
            if (out_valid) begin
                lat = k;
                got = {ovf, cout, sum};
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            in_valid = 1'($urandom); a = W'($urandom); b = W'($urandom);
            cin = 1'($urandom); sub = 1'($urandom); out_ready = 1'($urandom);
            #1;
            tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
            tests++; if (sum !== 16'h0000) begin fails++; $display("FAIL rst_sum got=%h want=0000", sum); end
            tests++; if (cout !== 1'b0) begin fails++; $display("FAIL rst_cout got=%b want=0", cout); end
            tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL rst_ovf got=%b want=0", ovf); end
            tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rst_in_ready got=%b want=0", in_ready); end
        end
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_release_in_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_add_wrap();
        logic acc; logic [17:0] got; int lat;
        run_one(16'hFFFF, 16'h0001, 1'b0, 1'b0, acc, got, lat);
        tests++; if (acc !== 1'b1) begin fails++; $display("FAIL wrap_accept got=%b want=1", acc); end
        tests++; if (lat != LAT) begin fails++; $display("FAIL wrap_latency got=%0d want=%0d", lat, LAT); end
        tests++; if (got !== {1'b0, 1'b1, 16'h0000}) begin fails++; $display("FAIL wrap_cin0 got=%h want=%h", got, {1'b0, 1'b1, 16'h0000}); end
        run_one(16'hFFFF, 16'h0001, 1'b1, 1'b0, acc, got, lat);
        tests++; if (lat != LAT) begin fails++; $display("FAIL wrap_cin1_latency got=%0d want=%0d", lat, LAT); end
        tests++; if (got !== {1'b0, 1'b1, 16'h0001}) begin fails++; $display("FAIL wrap_cin1 got=%h want=%h", got, {1'b0, 1'b1, 16'h0001}); end
    endtask

    task automatic test_overflow();
        logic acc; logic [17:0] got; int lat;
        run_one(16'h7FFF, 16'h0001, 1'b0, 1'b0, acc, got, lat);
        tests++; if (got !== {1'b1, 1'b0, 16'h8000}) begin fails++; $display("FAIL ovf_add got=%h want=%h", got, {1'b1, 1'b0, 16'h8000}); end
        run_one(16'h8000, 16'h0001, 1'b1, 1'b1, acc, got, lat);
        tests++; if (got !== {1'b1, 1'b1, 16'h7FFF}) begin fails++; $display("FAIL ovf_sub got=%h want=%h", got, {1'b1, 1'b1, 16'h7FFF}); end
        run_one(16'h0000, 16'h0001, 1'b0, 1'b1, acc, got, lat);
        tests++; if (got !== {1'b0, 1'b0, 16'hFFFF}) begin fails++; $display("FAIL sub_borrow got=%h want=%h", got, {1'b0, 1'b0, 16'hFFFF}); end
        tests++; if (lat != LAT) begin fails++; $display("FAIL sub_latency got=%0d want=%0d", lat, LAT); end
    endtask

    task automatic test_backpressure();
        int acc_n = 0, emit_n = 0, cyc = 0;
        logic held = 1'b0;
        logic [17:0] prev = '0, e;
        expq.delete();
        while ((acc_n < 200 || expq.size() > 0) && cyc < 3000) begin
            @(posedge clk); #1;
            in_valid = (acc_n < 200) && ($urandom_range(0, 3) != 0);
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            #1;
            if (held) begin
                tests++;
                if ({out_valid, ovf, cout, sum} !== {1'b1, prev}) begin
                    fails++; $display("FAIL bp_hold got=%b/%h want=1/%h", out_valid, {ovf, cout, sum}, prev);
                end
            end
            if (out_valid && out_ready) begin
                tests++;
                emit_n++;
                if (expq.size() == 0) begin
                    fails++; $display("FAIL bp_extra_beat got=%h want=none", {ovf, cout, sum});
                end else begin
                    e = expq.pop_front();
                    if ({ovf, cout, sum} !== e) begin
                        fails++; $display("FAIL bp_result got=%h want=%h", {ovf, cout, sum}, e);
                    end
                end
            end
            if (in_valid && in_ready) begin
                expq.push_back(model(a, b, cin, sub));
                acc_n++;
            end
            held = out_valid && !out_ready;
            prev = {ovf, cout, sum};
            cyc++;
        end
        in_valid = 1'b0;
        tests++;
        if (acc_n != 200 || emit_n != 200 || expq.size() != 0) begin
            fails++; $display("FAIL bp_count got acc=%0d emit=%0d left=%0d want 200/200/0", acc_n, emit_n, expq.size());
        end
    endtask

    task automatic test_full_rate();
        int run = 0;
        logic exp_v;
        logic [17:0] e;
        expq.delete();
        for (int c = 0; c < 76; c++) begin
            @(posedge clk); #1;
            in_valid = (c < 64);
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
            out_ready = 1'b1;
            #1;
            exp_v = (c >= LAT) && (c < 64 + LAT);
            tests++;
            if (out_valid !== exp_v) begin
                fails++; $display("FAIL fr_valid cycle=%0d got=%b want=%b", c, out_valid, exp_v);
            end
            if (out_valid) begin
                run++;
                if (expq.size() > 0) begin
                    e = expq.pop_front();
                    tests++;
                    if ({ovf, cout, sum} !== e) begin
                        fails++; $display("FAIL fr_result got=%h want=%h", {ovf, cout, sum}, e);
                    end
                end
            end
            if (c < 64) begin
                tests++;
                if (in_ready !== 1'b1) begin fails++; $display("FAIL fr_in_ready cycle=%0d got=%b want=1", c, in_ready); end
            end
            if (in_valid && in_ready) expq.push_back(model(a, b, cin, sub));
        end
        in_valid = 1'b0;
        tests++;
        if (run != 64) begin fails++; $display("FAIL fr_run got=%0d want=64", run); end
    endtask

    task automatic test_reset_mid();
        logic [17:0] e = '0;
        for (int c = 0; c < 13; c++) begin
            @(posedge clk); #1;
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
            out_ready = 1'b1;
            rst      = (c == 3);
            in_valid = (c <= 3) || (c == 5);
            if (c == 5) e = model(a, b, cin, sub);
            #1;
            if (c == 3) begin
                tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rm_in_ready_rst got=%b want=0", in_ready); end
            end
            if (c == 5) begin
                tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rm_in_ready_post got=%b want=1", in_ready); end
            end
            if (c >= 3) begin
                tests++;
                if (out_valid !== (c == 9)) begin
                    fails++; $display("FAIL rm_valid cycle=%0d got=%b want=%b", c, out_valid, (c == 9));
                end
            end
            if (c == 9) begin
                tests++;
                if ({ovf, cout, sum} !== e) begin fails++; $display("FAIL rm_result got=%h want=%h", {ovf, cout, sum}, e); end
            end
        end
        rst = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_add_wrap();
        test_overflow();
        test_backpressure();
        test_full_rate();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
